char_pixel_renderer: RTL and testbench

- Consumer end of the character-address path in the VGA text display.
- Takes the per-pixel character code with its x/y coordinates, reads the glyph row from a synchronous font ROM, and selects the glyph bit for the current pixel.
- Outputs registered RGB with hsync/vsync delayed to match, ready for the VGA pins.
- Glyph cell is 16 px wide x 32 px tall; character code 0 means blank.

---
 rtl/char_pixel_renderer.sv | 144 ++++++++++++++
 tb/tb_char_pixel_renderer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/char_pixel_renderer.sv
// char_pixel_renderer: last stage of the text-mode video path.
// Looks up the glyph row for the current character in a synchronous font
// ROM, picks the bit for the pixel column and drives registered RGB plus
// hsync/vsync delayed to match. Two pix_valid strobes of latency.
// Optional blinking cursor cell is built when the macro CURSOR_EN is defined.
module char_pixel_renderer #(
    parameter int RGB_W        = 12,
    parameter int BLINK_FRAMES = 30
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pix_valid,
    input  logic [9:0]       x,
    input  logic [9:0]       y,
    input  logic [6:0]       char_addr,
    input  logic             video_on,
    input  logic             hsync_in,
    input  logic             vsync_in,
`ifdef CURSOR_EN
    input  logic [5:0]       cursor_col,
    input  logic [4:0]       cursor_row,
`endif
    output logic [11:0]      rom_addr,
    input  logic [15:0]      rom_data,
    input  logic [RGB_W-1:0] fg_color,
    input  logic [RGB_W-1:0] bg_color,
    output logic [RGB_W-1:0] rgb,
    output logic             hsync_out,
    output logic             vsync_out,
    output logic             pix_out_valid
);

    // stage 1: ROM address and per-pixel attributes
    logic [11:0]      rom_addr_q;
    logic [3:0]       col_q;
    logic             blank_q;
    logic             on_q;
    logic             hs1_q;
    logic             vs1_q;
    // stage 2: pixel outputs
    logic [RGB_W-1:0] rgb_q;
    logic [RGB_W-1:0] rgb_d;
    logic             glyph_bit_d;
    logic             hs2_q;
    logic             vs2_q;
    logic             pix_out_valid_q;

`ifdef CURSOR_EN
    localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CW-1:0] LAST_FRAME = CW'(BLINK_FRAMES - 1);

    logic          hit_q;
    logic [CW-1:0] frame_cnt_q;
    logic          blink_phase_q;
`else
    // Upper coordinate bits only select the cursor cell.
    logic unused_coord;
    assign unused_coord = ^{x[9:4], y[9:5]};
`endif

    // Stage 1 capture; everything holds while pix_valid is low so the ROM
    // address (and therefore rom_data) stays stable across any stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr_q <= '0;
            col_q      <= '0;
            blank_q    <= 1'b0;
            on_q       <= 1'b0;
            hs1_q      <= 1'b1;
            vs1_q      <= 1'b1;
        end else if (pix_valid) begin
            rom_addr_q <= {char_addr, y[4:0]};
            col_q      <= x[3:0];
            blank_q    <= (char_addr == 7'd0) | ~video_on;
            on_q       <= video_on;
            hs1_q      <= hsync_in;
            vs1_q      <= vsync_in;
        end
    end

`ifdef CURSOR_EN
    // Cursor cell match, captured alongside the rest of stage 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_q <= 1'b0;
        end else if (pix_valid) begin
            hit_q <= (x[9:4] == cursor_col) && (y[9:5] == cursor_row);
        end
    end

    // Frame counter on vsync falling edges; blink phase flips at each wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else if (pix_valid && vs1_q && !vsync_in) begin
            if (frame_cnt_q == LAST_FRAME) begin
                frame_cnt_q   <= '0;
                blink_phase_q <= ~blink_phase_q;
            end else begin
                frame_cnt_q <= frame_cnt_q + 1'b1;
            end
        end
    end
`endif

    // Glyph bit select (bit 15 is the leftmost pixel) and colour mux.
    always_comb begin
        glyph_bit_d = rom_data[~col_q] & ~blank_q;
`ifdef CURSOR_EN
        glyph_bit_d = glyph_bit_d ^ (hit_q & blink_phase_q & on_q);
`endif
        rgb_d = on_q ? (glyph_bit_d ? fg_color : bg_color) : '0;
    end

    // Stage 2 output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_q <= '0;
            hs2_q <= 1'b1;
            vs2_q <= 1'b1;
        end else if (pix_valid) begin
            rgb_q <= rgb_d;
            hs2_q <= hs1_q;
            vs2_q <= vs1_q;
        end
    end

    // Output strobe trails pix_valid by one clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_out_valid_q <= 1'b0;
        end else begin
            pix_out_valid_q <= pix_valid;
        end
    end

    assign rom_addr      = rom_addr_q;
    assign rgb           = rgb_q;
    assign hsync_out     = hs2_q;
    assign vsync_out     = vs2_q;
    assign pix_out_valid = pix_out_valid_q;

endmodule

// File: tb/tb_char_pixel_renderer.sv
// Scoreboard bench for char_pixel_renderer. Each strobe pushes the expected
// {hsync, vsync, rgb} for its inputs; the output seen after that same strobe
// is the result of the previous one and is popped from the queue.
`timescale 1ns/1ps
module tb_char_pixel_renderer;

    localparam int         RGB_W = 12;
    localparam int         BF    = 2;
    localparam logic [11:0] FG   = 12'hF5A;
    localparam logic [11:0] BG   = 12'h2C3;
    localparam logic [13:0] RST_PIX = 14'h3000;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             pix_valid = 1'b0;
    logic [9:0]       x = '0;
    logic [9:0]       y = '0;
    logic [6:0]       char_addr = '0;
    logic             video_on = 1'b0;
    logic             hsync_in = 1'b1;
    logic             vsync_in = 1'b1;
    logic [11:0]      rom_addr;
    logic [15:0]      rom_data = '0;
    logic [RGB_W-1:0] fg_color = FG;
    logic [RGB_W-1:0] bg_color = BG;
    logic [RGB_W-1:0] rgb;
    logic             hsync_out;
    logic             vsync_out;
    logic             pix_out_valid;
`ifdef CURSOR_EN
    logic [5:0]       cursor_col = 6'd1;
    logic [4:0]       cursor_row = 5'd5;
    int               cnt_m = 0;
    logic             phase_m = 1'b0;
    logic             vs_prev_m = 1'b1;
`endif

    char_pixel_renderer #(.RGB_W(RGB_W), .BLINK_FRAMES(BF)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pix_valid     (pix_valid),
        .x             (x),
        .y             (y),
        .char_addr     (char_addr),
        .video_on      (video_on),
        .hsync_in      (hsync_in),
        .vsync_in      (vsync_in),
`ifdef CURSOR_EN
        .cursor_col    (cursor_col),
        .cursor_row    (cursor_row),
`endif
        .rom_addr      (rom_addr),
        .rom_data      (rom_data),
        .fg_color      (fg_color),
        .bg_color      (bg_color),
        .rgb           (rgb),
        .hsync_out     (hsync_out),
        .vsync_out     (vsync_out),
        .pix_out_valid (pix_out_valid)
    );

    always #5 clk = ~clk;

    // synchronous font ROM model
    logic [15:0] rom [0:4095];
    always @(posedge clk) rom_data <= rom[rom_addr];

    logic [13:0] sb_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic        last_hs = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_rgb", rgb, 0);
        chk("rst_hs", hsync_out, 1);
        chk("rst_vs", vsync_out, 1);
        chk("rst_pov", pix_out_valid, 0);
        chk("rst_addr", rom_addr, 0);
        sb_q.delete();
        sb_q.push_back(RST_PIX);
`ifdef CURSOR_EN
        cnt_m = 0;
        phase_m = 1'b0;
        vs_prev_m = 1'b1;
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // One pixel strobe followed by `gap` idle clocks (gap >= 1).
    task automatic strobe(input logic [9:0] px, input logic [9:0] py, input logic [6:0] c,
                          input logic von, input logic hs, input logic vs, input int gap);
        logic [15:0] row;
        logic        b;
        logic [13:0] got;
        x = px; y = py; char_addr = c; video_on = von;
        hsync_in = hs; vsync_in = vs; pix_valid = 1'b1;
        row = rom[{c, py[4:0]}];
        b = row[15 - px[3:0]] && (c != 7'd0) && von;
`ifdef CURSOR_EN
        if (vs_prev_m && !vs) begin
            cnt_m++;
            if (cnt_m == BF) begin
                cnt_m = 0;
                phase_m = !phase_m;
            end
        end
        vs_prev_m = vs;
        if (px[9:4] == cursor_col && py[9:5] == cursor_row && phase_m && von) b = !b;
`endif
        sb_q.push_back({hs, vs, von ? (b ? FG : BG) : 12'h000});
        @(posedge clk); #1;
        pix_valid = 1'b0;
        chk("pov_hi", pix_out_valid, 1);
        chk("rom_addr", rom_addr, {c, py[4:0]});
        got = {hsync_out, vsync_out, rgb};
        chk("pix", got, sb_q.pop_front());
        last_hs = hsync_out;
        repeat (gap) begin
            @(posedge clk); #1;
        end
        chk("pov_lo", pix_out_valid, 0);
        chk("hold", {hsync_out, vsync_out, rgb}, got);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lows;
        int first_low;
        for (int i = 0; i < 4096; i++) rom[i] = 16'($urandom);
        for (int i = 0; i < 32; i++) rom[i] = 16'hFFFF;
        rom[12'h945] = 16'h8001;

        do_reset();

        // glyph bit select: fg at x=16 and 31 only
        for (int i = 16; i < 32; i++) strobe(10'(i), 10'd165, 7'h4A, 1'b1, 1'b1, 1'b1, 1);
        // blank character over an all-ones row -> background
        for (int i = 0; i < 16; i++) strobe(10'(i), 10'd165, 7'h00, 1'b1, 1'b1, 1'b1, 1);
        // video_on low -> black even with a real glyph
        for (int i = 16; i < 32; i++) strobe(10'(i), 10'd165, 7'h4A, 1'b0, 1'b1, 1'b1, 1);

        // one scan line with hsync low for x=656..751
        lows = 0;
        first_low = -1;
        for (int i = 0; i < 800; i++) begin
            strobe(10'(i), 10'd10, 7'h41, i < 640, !(i >= 656 && i < 752), 1'b1, 1);
            if (!last_hs) begin
                lows++;
                if (first_low < 0) first_low = i;
            end
        end
        chk("hs_low_len", lows, 96);
        chk("hs_first_low", first_low, 657);

        // random pixels with random stall gaps
        for (int i = 0; i < 150; i++)
            strobe(10'($urandom), 10'($urandom), 7'($urandom), 1'($urandom), 1'($urandom),
                   1'($urandom), $urandom_range(1, 5));

        // reset mid-stream, then resume
        do_reset();
        for (int i = 14; i < 34; i++) strobe(10'(i), 10'd165, 7'h4A, 1'b1, 1'b1, 1'b1, 2);

`ifdef CURSOR_EN
        for (int f = 0; f < 8; f++) begin
            strobe(10'd0, 10'd0, 7'h00, 1'b0, 1'b1, 1'b1, 1);
            strobe(10'd0, 10'd0, 7'h00, 1'b0, 1'b1, 1'b0, 1);
            strobe(10'd0, 10'd0, 7'h00, 1'b0, 1'b1, 1'b1, 1);
            for (int i = 0; i < 48; i++) strobe(10'(i), 10'd165, 7'h4A, 1'b1, 1'b1, 1'b1, 1);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
